// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port between I-cache line fills
// (locked BURST_LEN-word bursts) and single-word D-side reads.
module icache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_ic_req,
  input  logic [ADDR_WIDTH-1:0] i_ic_addr,
  output logic [DATA_WIDTH-1:0] o_ic_data,
  output logic                  o_ic_valid,
  output logic                  o_ic_done,
  input  logic                  i_dc_req,
  input  logic [ADDR_WIDTH-1:0] i_dc_addr,
  output logic [DATA_WIDTH-1:0] o_dc_data,
  output logic                  o_dc_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ack
);

  localparam int CW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_IBURST, S_DREAD} state_t;

  state_t          r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]   r_cnt;
  logic            r_last_i;
  logic            w_grant_i, w_grant_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_ic_valid   = 1'b0;
    o_ic_data    = '0;
    o_ic_done    = 1'b0;
    o_dc_valid   = 1'b0;
    o_dc_data    = '0;
    // Reset aborts the transaction in the same cycle: no strobe, no pulses.
    if (!i_reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (i_ic_req && (!i_dc_req || !r_last_i)) begin
            w_grant_i    = 1'b1;
            w_next_state = S_IBURST;
          end else if (i_dc_req) begin
            w_grant_d    = 1'b1;
            w_next_state = S_DREAD;
          end
        end
        S_IBURST: begin
          o_mem_rd   = 1'b1;
          o_mem_addr = {r_addr[ADDR_WIDTH-1:CW], r_cnt};
          if (i_mem_ack) begin
            o_ic_valid = 1'b1;
            o_ic_data  = i_mem_data;
            if (r_cnt == CW'(BURST_LEN - 1)) begin
              o_ic_done    = 1'b1;
              w_next_state = S_IDLE;
            end
          end
        end
        S_DREAD: begin
          o_mem_rd   = 1'b1;
          o_mem_addr = r_addr;
          if (i_mem_ack) begin
            o_dc_valid   = 1'b1;
            o_dc_data    = i_mem_data;
            w_next_state = S_IDLE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_last_i <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i) begin
        r_addr   <= {i_ic_addr[ADDR_WIDTH-1:CW], CW'(0)};
        r_cnt    <= '0;
        r_last_i <= 1'b1;
      end else if (w_grant_d) begin
        r_addr   <= i_dc_addr;
        r_cnt    <= '0;
        r_last_i <= 1'b0;
      end else if (r_state == S_IBURST && i_mem_ack) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Bench for icache_mem_arbiter: directed scenarios plus random traffic, all cycles
// checked against a queue-of-pending-reads reference model.
module tb_icache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, mem_ack;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] ic_data, dc_data;
  logic          ic_valid, ic_done, dc_valid, mem_rd;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  icache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_ic_req  (ic_req),
    .i_ic_addr (ic_addr),
    .o_ic_data (ic_data),
    .o_ic_valid(ic_valid),
    .o_ic_done (ic_done),
    .i_dc_req  (dc_req),
    .i_dc_addr (dc_addr),
    .o_dc_data (dc_data),
    .o_dc_valid(dc_valid),
    .o_mem_addr(mem_addr),
    .o_mem_rd  (mem_rd),
    .i_mem_data(mem_data),
    .i_mem_ack (mem_ack)
  );

  typedef struct {
    bit            is_i;
    logic [AW-1:0] addr;
    bit            last;
  } rd_t;

  rd_t           pending[$];
  bit            m_last_i;
  bit            chk_en;
  int            n_checks, n_pass;
  int            n_ic_valid, n_dc_valid, n_rd;
  logic [AW-1:0] ic_addr_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a grant in IDLE enqueues every word the transaction will read;
  // each acked strobe retires the head entry.
  always @(negedge clock) begin
    bit            e_rd, e_iv, e_dv, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_idata, e_ddata;
    rd_t           head;
    rd_t           ent;
    if (chk_en) begin
      e_rd = !reset && pending.size() > 0;
      e_addr = '0; e_iv = 0; e_dv = 0; e_done = 0; e_idata = '0; e_ddata = '0;
      if (e_rd) begin
        head   = pending[0];
        e_addr = head.addr;
        e_iv   = mem_ack && head.is_i;
        e_dv   = mem_ack && !head.is_i;
        e_done = e_iv && head.last;
        if (e_iv) e_idata = mem_data;
        if (e_dv) e_ddata = mem_data;
      end
      check("mem_rd",   64'(mem_rd),   64'(e_rd));
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      check("ic_valid", 64'(ic_valid), 64'(e_iv));
      check("ic_data",  64'(ic_data),  64'(e_idata));
      check("ic_done",  64'(ic_done),  64'(e_done));
      check("dc_valid", 64'(dc_valid), 64'(e_dv));
      check("dc_data",  64'(dc_data),  64'(e_ddata));
      if (mem_rd)   n_rd++;
      if (dc_valid) n_dc_valid++;
      if (ic_valid) begin
        n_ic_valid++;
        ic_addr_log.push_back(mem_addr);
      end
      // Advance the model to the state after the coming clock edge.
      if (reset) begin
        pending.delete();
        m_last_i = 1'b0;
      end else if (pending.size() > 0) begin
        if (mem_ack) void'(pending.pop_front());
      end else if (ic_req && (!dc_req || !m_last_i)) begin
        for (int k = 0; k < BL; k++) begin
          ent.is_i = 1'b1;
          ent.addr = (ic_addr & ~AW'(BL - 1)) + AW'(k);
          ent.last = (k == BL - 1);
          pending.push_back(ent);
        end
        m_last_i = 1'b1;
      end else if (dc_req) begin
        ent.is_i = 1'b0;
        ent.addr = dc_addr;
        ent.last = 1'b1;
        pending.push_back(ent);
        m_last_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    mem_data = $urandom;
  endtask

  task automatic wait_ic_done(input int budget);
    bit found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clock);
      if (ic_done === 1'b1) found = 1;
    end
    if (!found) check("ic_done_wait", 64'(0), 64'(1));
    tick();
  endtask

  task automatic wait_dc_valid(input int budget);
    bit found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clock);
      if (dc_valid === 1'b1) found = 1;
    end
    if (!found) check("dc_valid_wait", 64'(0), 64'(1));
    tick();
  endtask

  initial begin
    int d0, i0, r0;
    bit ic_done_s, dc_valid_s;
    reset = 1'b1; ic_req = 0; dc_req = 0; mem_ack = 0;
    ic_addr = '0; dc_addr = '0; mem_data = '0;
    m_last_i = 0; chk_en = 0;
    tick();
    chk_en = 1;
    tick(); tick();

    // 1: I-only line fill, ack every cycle.
    reset = 0; ic_req = 1; ic_addr = 32'h103; mem_ack = 1;
    i0 = n_ic_valid;
    ic_addr_log.delete();
    wait_ic_done(20);
    ic_req = 0;
    check("t1_valid_count", 64'(n_ic_valid - i0), 64'(4));
    check("t1_log_size", 64'(ic_addr_log.size()), 64'(4));
    if (ic_addr_log.size() == 4)
      for (int k = 0; k < 4; k++) check("t1_addr", 64'(ic_addr_log[k]), 64'(32'h100 + k));

    // 2: D-only read, three wait cycles before the ack.
    mem_ack = 0; dc_req = 1; dc_addr = 32'h55;
    r0 = n_rd; d0 = n_dc_valid;
    repeat (4) tick();
    mem_ack = 1;
    @(negedge clock);
    check("t2_dc_valid", 64'(dc_valid), 64'(1));
    check("t2_mem_addr", 64'(mem_addr), 64'(32'h55));
    tick();
    dc_req = 0; mem_ack = 0;
    check("t2_rd_cycles", 64'(n_rd - r0), 64'(4));
    check("t2_dc_count", 64'(n_dc_valid - d0), 64'(1));

    // 3: simultaneous requests after reset, then a second tie.
    reset = 1; tick(); tick();
    reset = 0; mem_ack = 1;
    ic_req = 1; ic_addr = 32'h200; dc_req = 1; dc_addr = 32'h77;
    d0 = n_dc_valid;
    wait_ic_done(20);
    ic_req = 0;
    check("t3_i_first", 64'(n_dc_valid - d0), 64'(0));
    wait_dc_valid(20);
    dc_req = 0;
    ic_req = 1; dc_req = 1;
    d0 = n_dc_valid;
    wait_ic_done(20);
    ic_req = 0;
    check("t3_rr_i_again", 64'(n_dc_valid - d0), 64'(0));
    wait_dc_valid(20);
    dc_req = 0;

    // 4: D request arrives mid-burst and must wait.
    ic_req = 1; ic_addr = 32'h3F2;
    tick(); tick();
    dc_req = 1; dc_addr = 32'h12;
    d0 = n_dc_valid;
    wait_ic_done(20);
    ic_req = 0;
    check("t4_no_d_midburst", 64'(n_dc_valid - d0), 64'(0));
    wait_dc_valid(20);
    dc_req = 0;

    // 5: reset at burst word 2, then the burst restarts from word 0.
    ic_req = 1; ic_addr = 32'h301;
    tick(); tick(); tick();
    reset = 1;
    ic_addr_log.delete();
    @(negedge clock);
    check("t5_valid_in_reset", 64'(ic_valid), 64'(0));
    check("t5_rd_in_reset", 64'(mem_rd), 64'(0));
    tick();
    reset = 0;
    wait_ic_done(20);
    ic_req = 0;
    check("t5_log_size", 64'(ic_addr_log.size()), 64'(4));
    if (ic_addr_log.size() > 0) check("t5_restart_addr", 64'(ic_addr_log[0]), 64'(32'h300));

    // 6: ack while idle is ignored.
    mem_ack = 1;
    i0 = n_ic_valid; d0 = n_dc_valid; r0 = n_rd;
    repeat (5) tick();
    check("t6_no_ic", 64'(n_ic_valid - i0), 64'(0));
    check("t6_no_dc", 64'(n_dc_valid - d0), 64'(0));
    check("t6_no_rd", 64'(n_rd - r0), 64'(0));

    // Random traffic against the model.
    ic_done_s = 0; dc_valid_s = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 199) == 0);
      if (!ic_req) begin
        if ($urandom_range(0, 3) == 0) begin ic_req = 1; ic_addr = $urandom; end
      end else if (ic_done_s || $urandom_range(0, 31) == 0) begin
        ic_req = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        ic_addr = $urandom;
      end
      if (!dc_req) begin
        if ($urandom_range(0, 3) == 0) begin dc_req = 1; dc_addr = $urandom; end
      end else if (dc_valid_s || $urandom_range(0, 31) == 0) begin
        dc_req = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        dc_addr = $urandom;
      end
      @(negedge clock);
      ic_done_s  = (ic_done === 1'b1);
      dc_valid_s = (dc_valid === 1'b1);
      tick();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
